// File: rtl/axil_arb_pkg.sv
// ============================================================================
//  Module      : axil_arb_pkg
//  Description : Shared types and constants for the AXI-Lite request arbiter.
//                Holds the arbiter state encoding, bus widths, response codes
//                and a helper for index-width calculation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axil_arb_pkg;

    localparam int AXIL_ADDR_W = 32;
    localparam int AXIL_DATA_W = 32;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [1:0] RESP_TIMEOUT = 2'b11;

    // DRAIN is only reachable when the watchdog is compiled in.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ISSUE = 3'd1,
        WR_WAIT  = 3'd2,
        RD_ISSUE = 3'd3,
        RD_WAIT  = 3'd4,
        DRAIN    = 3'd5
    } arb_state_e;

    // Width of an index into n requesters; never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : axil_arb_pkg

`default_nettype wire

// File: rtl/axil_arb_rr_pick.sv
// ============================================================================
//  Module      : axil_arb_rr_pick
//  Description : Combinational round-robin picker. Returns the first set bit
//                of the request vector strictly after the pointer position,
//                searching circularly, as both one-hot and binary index.
//  Ports       : i_req   - request vector, one bit per requester
//                i_ptr   - index of the previous winner
//                o_grant - one-hot winner (0 when nothing requested)
//                o_idx   - binary index of the winner
//                o_found - at least one request was present
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_arb_rr_pick
    import axil_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PW-1:0]      o_idx,
    output logic               o_found
);

    // Offset 1 is checked first so the last winner has lowest priority;
    // offset NUM_REQ wraps back onto the last winner itself.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int cand;
            cand = (int'(i_ptr) + k) % NUM_REQ;
            if (!o_found && i_req[cand]) begin
                o_found       = 1'b1;
                o_grant[cand] = 1'b1;
                o_idx         = PW'(cand);
            end
        end
    end

endmodule : axil_arb_rr_pick

`default_nettype wire

// File: rtl/axil_req_arbiter.sv
// ============================================================================
//  Module      : axil_req_arbiter
//  Description : Shares one axil_master command port between NUM_REQ
//                requesters. Round-robin grant per transaction, one
//                transaction outstanding downstream, responses routed back to
//                the granted requester only.
//  Ports       : aclk/areset        - clock, async active-high reset
//                s_wr_* / s_rd_*    - per-requester request/done interfaces,
//                                     32-bit fields packed 32*i, errors 2*i
//                m_wr_* / m_rd_*    - single downstream axil_master port
//                grant              - one-hot current owner, 0 when idle
//                timeout_flag       - sticky watchdog flag
//  Options     : `define ARB_TIMEOUT_EN enables a TIMEOUT_CYCLES watchdog on
//                the WAIT states; a timed-out requester gets RESP_TIMEOUT and
//                the late downstream done is drained. Without it the WAIT
//                states wait indefinitely and timeout_flag is tied 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_req_arbiter
    import axil_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           aclk,
    input  logic                           areset,
    // requester write side
    input  logic [NUM_REQ-1:0]             s_wr_valid,
    output logic [NUM_REQ-1:0]             s_wr_ready,
    input  logic [NUM_REQ*AXIL_ADDR_W-1:0] s_wr_addr,
    input  logic [NUM_REQ*AXIL_DATA_W-1:0] s_wr_data,
    output logic [NUM_REQ-1:0]             s_wr_done,
    output logic [NUM_REQ*2-1:0]           s_wr_error,
    // requester read side
    input  logic [NUM_REQ-1:0]             s_rd_valid,
    output logic [NUM_REQ-1:0]             s_rd_ready,
    input  logic [NUM_REQ*AXIL_ADDR_W-1:0] s_rd_addr,
    output logic [AXIL_DATA_W-1:0]         s_rd_data,
    output logic [NUM_REQ-1:0]             s_rd_done,
    output logic [NUM_REQ*2-1:0]           s_rd_error,
    // downstream write side
    output logic                           m_wr_valid,
    input  logic                           m_wr_ready,
    output logic [AXIL_ADDR_W-1:0]         m_wr_addr,
    output logic [AXIL_DATA_W-1:0]         m_wr_data,
    input  logic                           m_wr_done,
    input  logic [1:0]                     m_wr_error,
    // downstream read side
    output logic                           m_rd_valid,
    input  logic                           m_rd_ready,
    output logic [AXIL_ADDR_W-1:0]         m_rd_addr,
    input  logic [AXIL_DATA_W-1:0]         m_rd_data,
    input  logic                           m_rd_done,
    input  logic [1:0]                     m_rd_error,
    // status
    output logic [NUM_REQ-1:0]             grant,
    output logic                           timeout_flag
);

    localparam int PW = idx_width(NUM_REQ);

    // Out-of-range configurations leave this empty block as an elaboration
    // marker; the watchdog limit must fit the 16-bit counter.
    if (NUM_REQ < 1 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535)
    begin : g_bad_param
    end

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    arb_state_e             r_state_q,    w_state_d;
    logic [NUM_REQ-1:0]     r_grant_q,    w_grant_d;
    logic [PW-1:0]          r_ptr_q,      w_ptr_d;    // index of current/last owner
    logic [NUM_REQ-1:0]     r_wr_done_q,  w_wr_done_d;
    logic [NUM_REQ-1:0]     r_rd_done_q,  w_rd_done_d;
    logic [1:0]             r_wr_err_q [NUM_REQ];
    logic [1:0]             w_wr_err_d [NUM_REQ];
    logic [1:0]             r_rd_err_q [NUM_REQ];
    logic [1:0]             w_rd_err_d [NUM_REQ];
    logic [AXIL_DATA_W-1:0] r_rd_data_q,  w_rd_data_d;

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] c_to_last = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]            r_cnt_q,      w_cnt_d;
    logic                   r_flag_q,     w_flag_d;
`endif

    // ------------------------------------------------------------------
    // Unpack the per-requester buses
    // ------------------------------------------------------------------
    logic [AXIL_ADDR_W-1:0] w_wr_addr_arr [NUM_REQ];
    logic [AXIL_DATA_W-1:0] w_wr_data_arr [NUM_REQ];
    logic [AXIL_ADDR_W-1:0] w_rd_addr_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign w_wr_addr_arr[i]   = s_wr_addr[AXIL_ADDR_W*i +: AXIL_ADDR_W];
        assign w_wr_data_arr[i]   = s_wr_data[AXIL_DATA_W*i +: AXIL_DATA_W];
        assign w_rd_addr_arr[i]   = s_rd_addr[AXIL_ADDR_W*i +: AXIL_ADDR_W];
        assign s_wr_error[2*i +: 2] = r_wr_err_q[i];
        assign s_rd_error[2*i +: 2] = r_rd_err_q[i];
    end

    // ------------------------------------------------------------------
    // Round-robin selection
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0] w_pick_grant;
    logic [PW-1:0]      w_pick_idx;
    logic               w_pick_found;

    axil_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_pick (
        .i_req   (s_wr_valid | s_rd_valid),
        .i_ptr   (r_ptr_q),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d   = r_state_q;
        w_grant_d   = r_grant_q;
        w_ptr_d     = r_ptr_q;
        w_wr_done_d = '0;
        w_rd_done_d = '0;
        w_wr_err_d  = r_wr_err_q;
        w_rd_err_d  = r_rd_err_q;
        w_rd_data_d = r_rd_data_q;
`ifdef ARB_TIMEOUT_EN
        w_cnt_d     = r_cnt_q;
        w_flag_d    = r_flag_q;
`endif
        case (r_state_q)
            IDLE: begin
                if (w_pick_found) begin
                    w_grant_d = w_pick_grant;
                    w_ptr_d   = w_pick_idx;
                    // Write wins inside a requester; its read waits a full turn.
                    w_state_d = s_wr_valid[w_pick_idx] ? WR_ISSUE : RD_ISSUE;
                end
            end
            WR_ISSUE: begin
                if (m_wr_ready) begin
                    w_state_d = WR_WAIT;
`ifdef ARB_TIMEOUT_EN
                    w_cnt_d   = '0;
`endif
                end
            end
            WR_WAIT: begin
                if (m_wr_done) begin
                    w_wr_done_d[r_ptr_q] = 1'b1;
                    w_wr_err_d[r_ptr_q]  = m_wr_error;
                    w_grant_d            = '0;
                    w_state_d            = IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (r_cnt_q == c_to_last) begin
                    w_wr_done_d[r_ptr_q] = 1'b1;
                    w_wr_err_d[r_ptr_q]  = RESP_TIMEOUT;
                    w_flag_d             = 1'b1;
                    w_grant_d            = '0;
                    w_state_d            = DRAIN;
                end else begin
                    w_cnt_d = r_cnt_q + 16'd1;
                end
`endif
            end
            RD_ISSUE: begin
                if (m_rd_ready) begin
                    w_state_d = RD_WAIT;
`ifdef ARB_TIMEOUT_EN
                    w_cnt_d   = '0;
`endif
                end
            end
            RD_WAIT: begin
                if (m_rd_done) begin
                    w_rd_done_d[r_ptr_q] = 1'b1;
                    w_rd_err_d[r_ptr_q]  = m_rd_error;
                    w_rd_data_d          = m_rd_data;
                    w_grant_d            = '0;
                    w_state_d            = IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (r_cnt_q == c_to_last) begin
                    w_rd_done_d[r_ptr_q] = 1'b1;
                    w_rd_err_d[r_ptr_q]  = RESP_TIMEOUT;
                    w_flag_d             = 1'b1;
                    w_grant_d            = '0;
                    w_state_d            = DRAIN;
                end else begin
                    w_cnt_d = r_cnt_q + 16'd1;
                end
`endif
            end
`ifdef ARB_TIMEOUT_EN
            DRAIN: begin
                // Only one transaction is ever outstanding, so whichever
                // done arrives is the late one; it is swallowed here.
                if (m_wr_done || m_rd_done) begin
                    w_state_d = IDLE;
                end
            end
`endif
            default: begin
                w_state_d = IDLE;
                w_grant_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state_q   <= IDLE;
            r_grant_q   <= '0;
            r_ptr_q     <= PW'(NUM_REQ - 1);   // requester 0 wins first
            r_wr_done_q <= '0;
            r_rd_done_q <= '0;
            r_rd_data_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_wr_err_q[i] <= RESP_OKAY;
                r_rd_err_q[i] <= RESP_OKAY;
            end
`ifdef ARB_TIMEOUT_EN
            r_cnt_q     <= '0;
            r_flag_q    <= 1'b0;
`endif
        end else begin
            r_state_q   <= w_state_d;
            r_grant_q   <= w_grant_d;
            r_ptr_q     <= w_ptr_d;
            r_wr_done_q <= w_wr_done_d;
            r_rd_done_q <= w_rd_done_d;
            r_rd_data_q <= w_rd_data_d;
            r_wr_err_q  <= w_wr_err_d;
            r_rd_err_q  <= w_rd_err_d;
`ifdef ARB_TIMEOUT_EN
            r_cnt_q     <= w_cnt_d;
            r_flag_q    <= w_flag_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign m_wr_valid = (r_state_q == WR_ISSUE);
    assign m_rd_valid = (r_state_q == RD_ISSUE);
    assign m_wr_addr  = w_wr_addr_arr[r_ptr_q];
    assign m_wr_data  = w_wr_data_arr[r_ptr_q];
    assign m_rd_addr  = w_rd_addr_arr[r_ptr_q];

    // Accept is passed straight through to the owner only.
    assign s_wr_ready = m_wr_valid ? (r_grant_q & {NUM_REQ{m_wr_ready}}) : '0;
    assign s_rd_ready = m_rd_valid ? (r_grant_q & {NUM_REQ{m_rd_ready}}) : '0;

    assign s_wr_done  = r_wr_done_q;
    assign s_rd_done  = r_rd_done_q;
    assign s_rd_data  = r_rd_data_q;
    assign grant      = r_grant_q;

`ifdef ARB_TIMEOUT_EN
    assign timeout_flag = r_flag_q;
`else
    assign timeout_flag = 1'b0;
`endif

endmodule : axil_req_arbiter

`default_nettype wire
